upsp_ac_ctrl: RTL

Access-controller frame sequencer for the up-sampling module (upsp). It starts a frame when software sets the UPSTR start bit. It serves upsp read requests from an upstream input pixel stream and drains upsp write data into a downstream output stream. It counts input and output pixels against the frame geometry and reports completion through UPENDR.

---
 rtl/upsp_ac_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/upsp_ac_ctrl.sv
// Access-controller frame sequencer for the upsp up-sampler: serves upsp pixel
// reads from an input stream, drains upsp writes through a 2-entry FIFO to an output stream.
module upsp_ac_ctrl #(
    parameter int CRF_DATA_WIDTH  = 32,
    parameter int UPSP_DATA_WIDTH = 24,
    parameter int SRC_W           = 960,
    parameter int SRC_H           = 540,
    parameter int SCALE           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CRF_DATA_WIDTH-1:0]  UPSTR,
    output logic [CRF_DATA_WIDTH-1:0]  UPENDR,
    output logic                       busy,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [UPSP_DATA_WIDTH-1:0] s_tdata,
    input  logic                       upsp_ac_rd,
    output logic                       ac_upsp_rvalid,
    output logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
    output logic                       ac_upsp_wready,
    input  logic                       upsp_ac_wrt,
    input  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [UPSP_DATA_WIDTH-1:0] m_tdata,
    output logic                       m_tlast
);

    localparam int IN_TOTAL  = SRC_W * SRC_H;
    localparam int OUT_TOTAL = IN_TOTAL * SCALE * SCALE;
    localparam int CW        = $clog2(OUT_TOTAL + 1);

    localparam logic [CW-1:0] IN_TOTAL_C  = CW'(IN_TOTAL);
    localparam logic [CW-1:0] OUT_TOTAL_C = CW'(OUT_TOTAL);
    localparam logic [CW-1:0] OUT_LAST_C  = CW'(OUT_TOTAL - 1);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO_C  = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic                       start_q, start_d;
    logic                       pend_q, pend_d;
    logic [CW-1:0]              rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]              out_cnt_q, out_cnt_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       rvalid_q, rvalid_d;
    logic [UPSP_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [UPSP_DATA_WIDTH-1:0] mem_q [0:1];
    logic [UPSP_DATA_WIDTH-1:0] mem_d [0:1];
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 fifo_cnt_q, fifo_cnt_d;
    logic                       wready_q, wready_d;
    logic                       mvalid_q, mvalid_d;
    logic [UPSP_DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                       mlast_q, mlast_d;
    logic                       busy_q, busy_d;

    logic run_s, start_edge_s, rd_accept_s, rd_err_s, s_hs_s, push_s, pop_s, wr_err_s;
    logic upstr_unused_s;

    assign run_s        = (state_q == ST_RUN);
    assign start_edge_s = UPSTR[0] & ~start_q;
    assign rd_accept_s  = run_s & upsp_ac_rd & ~pend_q & (rd_cnt_q < IN_TOTAL_C);
    assign rd_err_s     = run_s & upsp_ac_rd & (pend_q | (rd_cnt_q >= IN_TOTAL_C));
    assign s_hs_s       = s_tvalid & pend_q;
    assign push_s       = upsp_ac_wrt & wready_q;
    assign wr_err_s     = run_s & upsp_ac_wrt & ~wready_q;
    assign pop_s        = mvalid_q & m_tready;

    assign upstr_unused_s = ^UPSTR[CRF_DATA_WIDTH-1:1];

    // Next-state for datapath, FIFO and frame FSM; outputs are derived from next state.
    always_comb begin
        state_d    = state_q;
        start_d    = UPSTR[0];
        pend_d     = pend_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        out_cnt_d  = out_cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        if (s_hs_s) begin
            pend_d   = 1'b0;
            rd_cnt_d = rd_cnt_q + CNT_ONE_C;
            rvalid_d = 1'b1;
            rdata_d  = s_tdata;
        end else if (rd_accept_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        if (rd_err_s || wr_err_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (push_s) begin
            mem_d[wr_ptr_q] = upsp_ac_wdata;
            wr_ptr_d        = ~wr_ptr_q;
            wr_cnt_d        = wr_cnt_q + CNT_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d  = ~rd_ptr_q;
            out_cnt_d = out_cnt_q + CNT_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // Frame control overrides the datapath updates when a new frame starts.
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d    = ST_RUN;
                    pend_d     = 1'b0;
                    rd_cnt_d   = CNT_ZERO_C;
                    wr_cnt_d   = CNT_ZERO_C;
                    out_cnt_d  = CNT_ZERO_C;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                    fifo_cnt_d = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && (out_cnt_q == OUT_LAST_C)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!UPSTR[0]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wready_d = (state_d == ST_RUN) && (fifo_cnt_d != 2'd2) && (wr_cnt_d < OUT_TOTAL_C);
    assign mvalid_d = (fifo_cnt_d != 2'd0);
    assign mdata_d  = mem_d[rd_ptr_d];
    assign mlast_d  = mvalid_d && (out_cnt_d == OUT_LAST_C);
    assign busy_d   = (state_d == ST_RUN);

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            pend_q     <= 1'b0;
            rd_cnt_q   <= CNT_ZERO_C;
            wr_cnt_q   <= CNT_ZERO_C;
            out_cnt_q  <= CNT_ZERO_C;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= {UPSP_DATA_WIDTH{1'b0}};
            mem_q[0]   <= {UPSP_DATA_WIDTH{1'b0}};
            mem_q[1]   <= {UPSP_DATA_WIDTH{1'b0}};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            wready_q   <= 1'b0;
            mvalid_q   <= 1'b0;
            mdata_q    <= {UPSP_DATA_WIDTH{1'b0}};
            mlast_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            pend_q     <= pend_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            out_cnt_q  <= out_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            wready_q   <= wready_d;
            mvalid_q   <= mvalid_d;
            mdata_q    <= mdata_d;
            mlast_q    <= mlast_d;
            busy_q     <= busy_d;
        end
    end

    assign UPENDR         = {{(CRF_DATA_WIDTH-2){1'b0}}, err_q, done_q};
    assign busy           = busy_q;
    assign s_tready       = pend_q;
    assign ac_upsp_rvalid = rvalid_q;
    assign ac_upsp_rdata  = rdata_q;
    assign ac_upsp_wready = wready_q;
    assign m_tvalid       = mvalid_q;
    assign m_tdata        = mdata_q;
    assign m_tlast        = mlast_q;

endmodule
